// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/country signal controller and the country-road vehicle detector.
package traffic_pkg;

    localparam logic [2:0] LGT_RED = 3'b100;
    localparam logic [2:0] LGT_YEL = 3'b010;
    localparam logic [2:0] LGT_GRN = 3'b001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVE   = 2'd2,
        RELEASE = 2'd3
    } det_state_e;

    function automatic logic lght_valid(input logic [2:0] lght);
        return (lght == LGT_RED) || (lght == LGT_YEL) || (lght == LGT_GRN);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Loop-sensor debouncer: the level follows raw only after DEB_CYC consecutive agreeing samples.
module sensor_debounce #(
    parameter int DEB_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // The counter tracks the current run of samples that disagree with the level;
    // a sample matching the level breaks the run.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (raw != level_q) begin
            if (cnt_q == LAST) level_d = raw;
            else               cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/country_vehicle_detector.sv
// Country-road car detector: debounced arrival/exit loops, queue count and request FSM.
// Define COUNTRY_STATS_EN to build the served_total exit counter.
module country_vehicle_detector
    import traffic_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int DEB_CYC = 3,
    parameter int GAP_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arr_raw,
    input  logic             exit_raw,
    input  logic [2:0]       cntr_lght,
    output logic             x,
    output logic [CNT_W-1:0] queue_cnt,
    output logic             ovf,
    output logic             unf,
    output logic             code_err,
    output logic [15:0]      served_total
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    logic arr_lvl, exit_lvl;
    logic arr_prev_q, exit_prev_q;
    logic arr_ev, exit_ev, dec_ev;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, cerr_q, cerr_d;
    det_state_e       state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             lv;

    sensor_debounce #(.DEB_CYC(DEB_CYC)) u_arr_deb (
        .clk(clk), .rst(rst), .raw(arr_raw), .level(arr_lvl)
    );

    sensor_debounce #(.DEB_CYC(DEB_CYC)) u_exit_deb (
        .clk(clk), .rst(rst), .raw(exit_raw), .level(exit_lvl)
    );

    assign arr_ev  = arr_lvl & ~arr_prev_q;
    assign exit_ev = exit_lvl & ~exit_prev_q;
    assign dec_ev  = exit_ev & ~arr_ev & (cnt_q != '0);
    assign lv      = lght_valid(cntr_lght);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (arr_ev && !exit_ev) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
        end else if (exit_ev && !arr_ev) begin
            if (cnt_q == '0) unf_d = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Illegal light codes freeze the FSM (and its gap timer) except for IDLE,
    // whose only exit condition does not look at the light.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cerr_d  = cerr_q | ~lv;
        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (lv && cntr_lght != LGT_RED) cerr_d = 1'b1;
                if (cnt_q != '0) state_d = REQ;
            end
            REQ: begin
                if (cntr_lght == LGT_GRN)      state_d = SERVE;
                else if (cntr_lght == LGT_YEL) cerr_d  = 1'b1;
            end
            SERVE: begin
                if (cntr_lght == LGT_RED) begin
                    gap_d   = '0;
                    state_d = (cnt_q != '0) ? REQ : IDLE;
                end else if (lv) begin
                    if (cnt_q != '0 || arr_ev) begin
                        gap_d = '0;
                    end else if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = RELEASE;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            RELEASE: begin
                if (cntr_lght == LGT_RED) state_d = (cnt_q != '0) ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_prev_q  <= 1'b0;
            exit_prev_q <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            cerr_q      <= 1'b0;
            state_q     <= IDLE;
            gap_q       <= '0;
        end else begin
            arr_prev_q  <= arr_lvl;
            exit_prev_q <= exit_lvl;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            cerr_q      <= cerr_d;
            state_q     <= state_d;
            gap_q       <= gap_d;
        end
    end

`ifdef COUNTRY_STATS_EN
    logic [15:0] served_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         served_q <= '0;
        else if (dec_ev) served_q <= served_q + 16'd1;
    end

    assign served_total = served_q;
`else
    assign served_total = '0;
`endif

    assign x         = (state_q == REQ) || (state_q == SERVE);
    assign queue_cnt = cnt_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign code_err  = cerr_q;

endmodule
